// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: four-digit BCD up/down counter with a free-running digit
// scanner that presents one nibble at a time to a downstream 7-seg decoder.
module bcd_scan_counter #(
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Clear,
   input  logic        Load,
   input  logic [15:0] LoadVal,
   input  logic        Up,
   input  logic        Down,
   output logic [15:0] Count,
   output logic [3:0]  BCDOut,
   output logic [3:0]  DigitSel,
   output logic        Carry,
   output logic        Borrow
);

   localparam logic [15:0] PRE_LAST = 16'(SCAN_DIV - 1);

   logic [15:0] count_q, count_d;
   logic        carry_q, carry_d;
   logic        borrow_q, borrow_d;
   logic [15:0] pre_q, pre_d;
   logic [1:0]  idx_q, idx_d;

   logic [15:0] inc_val, dec_val, load_sat;
   logic [4:0]  inc_chain, dec_chain;

   assign inc_chain[0] = 1'b1;
   assign dec_chain[0] = 1'b1;

   // per-digit ripple: carry/borrow propagates through digits sitting at 9/0
   for (genvar g = 0; g < 4; g++) begin : g_dig
      logic [3:0] dig;
      assign dig = count_q[4*g +: 4];
      assign inc_val[4*g +: 4]  = inc_chain[g] ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
      assign inc_chain[g+1]     = inc_chain[g] & (dig == 4'd9);
      assign dec_val[4*g +: 4]  = dec_chain[g] ? ((dig == 4'd0) ? 4'd9 : dig - 4'd1) : dig;
      assign dec_chain[g+1]     = dec_chain[g] & (dig == 4'd0);
      assign load_sat[4*g +: 4] = (LoadVal[4*g +: 4] > 4'd9) ? 4'd9 : LoadVal[4*g +: 4];
   end

   // next count and wrap flags, in priority order
   always_comb begin
      count_d  = count_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      if (Clear) begin
         count_d = 16'h0000;
      end else if (Load) begin
         count_d = load_sat;
      end else if (Up && Down) begin
         count_d = count_q;
      end else if (Up) begin
         count_d = inc_val;
         carry_d = inc_chain[4];
      end else if (Down) begin
         count_d  = dec_val;
         borrow_d = dec_chain[4];
      end
   end

   // prescaler and digit index, independent of count activity
   always_comb begin
      pre_d = pre_q + 16'd1;
      idx_d = idx_q;
      if (pre_q >= PRE_LAST) begin
         pre_d = 16'd0;
         idx_d = idx_q + 2'd1;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= 16'h0000;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         pre_q    <= 16'd0;
         idx_q    <= 2'd0;
      end else begin
         count_q  <= count_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
         pre_q    <= pre_d;
         idx_q    <= idx_d;
      end
   end

   // scan outputs decoded straight from registers
   always_comb begin
      case (idx_q)
         2'd0:    BCDOut = count_q[3:0];
         2'd1:    BCDOut = count_q[7:4];
         2'd2:    BCDOut = count_q[11:8];
         default: BCDOut = count_q[15:12];
      endcase
      DigitSel = ~(4'b0001 << idx_q);
   end

   assign Count  = count_q;
   assign Carry  = carry_q;
   assign Borrow = borrow_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: directed checks of count priority, BCD wrap flags,
// async reset and scan sequencing at SCAN_DIV=3 and SCAN_DIV=1.
module tb_bcd_scan_counter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Clear = 1'b0, Load = 1'b0, Up = 1'b0, Down = 1'b0;
   logic [15:0] LoadVal = 16'h0000;

   logic [15:0] Count, Count1;
   logic [3:0]  BCDOut, BCDOut1, DigitSel, DigitSel1;
   logic        Carry, Carry1, Borrow, Borrow1;

   int errors = 0;
   int checks = 0;

   bcd_scan_counter #(.SCAN_DIV(3)) dut (
      .clk(clk), .rst_n(rst_n), .Clear(Clear), .Load(Load), .LoadVal(LoadVal),
      .Up(Up), .Down(Down), .Count(Count), .BCDOut(BCDOut), .DigitSel(DigitSel),
      .Carry(Carry), .Borrow(Borrow)
   );

   bcd_scan_counter #(.SCAN_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .Clear(Clear), .Load(Load), .LoadVal(LoadVal),
      .Up(Up), .Down(Down), .Count(Count1), .BCDOut(BCDOut1), .DigitSel(DigitSel1),
      .Carry(Carry1), .Borrow(Borrow1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // apply inputs for one edge, then sample 1 time unit after it
   task automatic step(input logic clr, input logic ld, input logic [15:0] lv,
                       input logic u, input logic d);
      Clear = clr; Load = ld; LoadVal = lv; Up = u; Down = d;
      @(posedge clk); #1;
      Clear = 1'b0; Load = 1'b0; Up = 1'b0; Down = 1'b0;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_cnt"}, Count, 16'h0000);
      chk({tag, "_bcd"}, {12'd0, BCDOut}, 16'h0000);
      chk({tag, "_sel"}, {12'd0, DigitSel}, 16'h000E);
      chk({tag, "_cb"},  {14'd0, Carry, Borrow}, 16'h0000);
   endtask

   initial begin
      logic [15:0] pat;
      logic [3:0]  edig, esel;
      int          ix;

      // reset state, no clock edge yet
      #2;
      chk_rst("rst_init");

      // release with Load of 4321 pending; scan frame from release
      @(posedge clk); #1;
      Load = 1'b1; LoadVal = 16'h4321; rst_n = 1'b1;
      #1;
      chk("scan_pre_sel", {12'd0, DigitSel}, 16'h000E);
      chk("scan_pre_bcd", {12'd0, BCDOut}, 16'h0000);
      step(1'b0, 1'b1, 16'h4321, 1'b0, 1'b0);
      pat = 16'h4321;
      for (int k = 1; k <= 13; k++) begin
         if (k > 1) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
         ix   = (k / 3) % 4;
         edig = pat[4*ix +: 4];
         esel = ~(4'b0001 << ix);
         chk($sformatf("scan3_bcd_%0d", k), {12'd0, BCDOut}, {12'd0, edig});
         chk($sformatf("scan3_sel_%0d", k), {12'd0, DigitSel}, {12'd0, esel});
         ix   = k % 4;
         edig = pat[4*ix +: 4];
         esel = ~(4'b0001 << ix);
         chk($sformatf("scan1_bcd_%0d", k), {12'd0, BCDOut1}, {12'd0, edig});
         chk($sformatf("scan1_sel_%0d", k), {12'd0, DigitSel1}, {12'd0, esel});
      end

      // increment chain
      step(1'b0, 1'b1, 16'h0999, 1'b0, 1'b0);
      chk("ld_0999", Count, 16'h0999);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("inc_1000", Count, 16'h1000);
      chk("inc_1000_c", {15'd0, Carry}, 16'h0000);
      step(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
      chk("ld_9999_c", {15'd0, Carry}, 16'h0000);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("wrap_up", Count, 16'h0000);
      chk("wrap_up_c", {15'd0, Carry}, 16'h0001);
      chk("wrap_up_b", {15'd0, Borrow}, 16'h0000);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("wrap_up_c_clr", {15'd0, Carry}, 16'h0000);
      chk("wrap_up_hold", Count, 16'h0000);

      // decrement chain
      step(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      chk("dec_0999", Count, 16'h0999);
      chk("dec_0999_b", {15'd0, Borrow}, 16'h0000);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("clr_0000", Count, 16'h0000);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      chk("wrap_dn", Count, 16'h9999);
      chk("wrap_dn_b", {15'd0, Borrow}, 16'h0001);
      chk("wrap_dn_c", {15'd0, Carry}, 16'h0000);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("wrap_dn_b_clr", {15'd0, Borrow}, 16'h0000);

      // priority
      step(1'b0, 1'b1, 16'h4321, 1'b0, 1'b0);
      step(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0);
      chk("pri_clr", Count, 16'h0000);
      step(1'b0, 1'b1, 16'h5678, 1'b1, 1'b0);
      chk("pri_load", Count, 16'h5678);
      step(1'b0, 1'b1, 16'h4321, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      chk("pri_updn", Count, 16'h4321);
      step(1'b0, 1'b1, 16'hA3F2, 1'b0, 1'b0);
      chk("ld_sat", Count, 16'h9392);
      step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      chk("ld_sat_all", Count, 16'h9999);
      chk("ld_no_flag", {14'd0, Carry, Borrow}, 16'h0000);

      // back-to-back up
      step(1'b0, 1'b1, 16'h0998, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("b2b_1", Count, 16'h0999);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("b2b_2", Count, 16'h1000);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("b2b_3", Count, 16'h1001);

      // async reset mid-count
      step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
      chk("ld_1234", Count, 16'h1234);
      #2 rst_n = 1'b0;
      #1;
      chk_rst("rst_mid");

      // async reset while a carry pulse is showing
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("rst_wrap_c", {15'd0, Carry}, 16'h0001);
      #1 rst_n = 1'b0;
      #1;
      chk_rst("rst_wrap");

      // count change seen on BCDOut with scan parked on digit 0
      @(posedge clk); #1;
      Load = 1'b1; LoadVal = 16'h0009; rst_n = 1'b1;
      step(1'b0, 1'b1, 16'h0009, 1'b0, 1'b0);
      chk("cds_bcd9", {12'd0, BCDOut}, 16'h0009);
      chk("cds_sel9", {12'd0, DigitSel}, 16'h000E);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("cds_bcd0", {12'd0, BCDOut}, 16'h0000);
      chk("cds_sel0", {12'd0, DigitSel}, 16'h000E);
      chk("cds_cnt", Count, 16'h0010);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("cds_next_bcd", {12'd0, BCDOut}, 16'h0001);
      chk("cds_next_sel", {12'd0, DigitSel}, 16'h000D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
